// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and transmitter state encoding
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   function automatic logic is_last_bit(input logic [2:0] idx);
      return idx == 3'(DATA_BITS - 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_i,
   output logic [DW-1:0] rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_ok, rd_ok;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A write while full is dropped even if a pop happens on the same edge.
   assign wr_ok = wr_i & ~full_o;
   assign rd_ok = rd_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with internal baud divider
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DIV = 2604,
   parameter int AW  = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [7:0]    DATA,
   input  logic          WR_EN,
   output logic          FULL,
   output logic          EMPTY,
   output logic [AW:0]   COUNT,
   output logic          BUSY,
   output logic          OVERRUN,
   output logic          TX
);

   localparam int BW = $clog2(DIV);

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovr_q, ovr_d;
   logic          tick, pop;
   logic [7:0]    head;

   sync_fifo #(.AW(AW), .DW(8)) u_fifo (
      .clk_i     (CLK),
      .rst_i     (RST),
      .wr_i      (WR_EN),
      .wr_data_i (DATA),
      .rd_i      (pop),
      .rd_data_o (head),
      .full_o    (FULL),
      .empty_o   (EMPTY),
      .count_o   (COUNT)
   );

   assign tick    = (baud_q == BW'(DIV - 1));
   assign BUSY    = (state_q != S_IDLE);
   assign OVERRUN = ovr_q;
   assign TX      = tx_q;
   assign ovr_d   = ovr_q | (WR_EN & FULL);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d   = IDLE_LVL;
            baud_d = '0;
            if (!EMPTY) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = S_START;
               tx_d    = START_LVL;
            end
         end
         S_START: begin
            if (tick) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tick) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (is_last_bit(bit_q)) begin
                  state_d = S_STOP;
                  tx_d    = STOP_LVL;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (tick) begin
               baud_d = '0;
               // Back-to-back frames: chain straight into the next start bit.
               if (!EMPTY) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = S_START;
                  tx_d    = START_LVL;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = IDLE_LVL;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = IDLE_LVL;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= IDLE_LVL;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-schedule model
module tb_uart_tx_fifo;

   localparam int D     = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int FRAME = 10 * D;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [7:0]    DATA = 8'h00;
   logic          WR_EN = 1'b0;
   logic          FULL, EMPTY, BUSY, OVERRUN, TX;
   logic [AW:0]   COUNT;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // Model: each accepted byte gets its frame start edge when it is accepted.
   int         m_acc[$];
   int         m_start[$];
   logic [7:0] m_byte[$];
   int         m_last_end = 0;
   logic       m_ovr = 1'b0;

   uart_tx_fifo #(.DIV(D), .AW(AW)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .DATA    (DATA),
      .WR_EN   (WR_EN),
      .FULL    (FULL),
      .EMPTY   (EMPTY),
      .COUNT   (COUNT),
      .BUSY    (BUSY),
      .OVERRUN (OVERRUN),
      .TX      (TX)
   );

   always #5 CLK = ~CLK;

   function automatic int count_at(input int t);
      int c = 0;
      for (int i = 0; i < m_acc.size(); i++) begin
         if (m_acc[i] <= t) c++;
         if (m_start[i] <= t) c--;
      end
      return c;
   endfunction

   function automatic logic tx_at(input int t);
      for (int i = 0; i < m_start.size(); i++) begin
         if (t >= m_start[i] && t < m_start[i] + FRAME) begin
            int b;
            b = (t - m_start[i]) / D;
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return m_byte[i][b-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic busy_at(input int t);
      for (int i = 0; i < m_start.size(); i++)
         if (t >= m_start[i] && t < m_start[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      int c;
      c = count_at(cyc);
      chk("TX",      32'(TX),      32'(tx_at(cyc)));
      chk("COUNT",   32'(COUNT),   32'(c));
      chk("FULL",    32'(FULL),    32'(c == DEPTH));
      chk("EMPTY",   32'(EMPTY),   32'(c == 0));
      chk("BUSY",    32'(BUSY),    32'(busy_at(cyc)));
      chk("OVERRUN", 32'(OVERRUN), 32'(m_ovr));
   endtask

   task automatic model_reset();
      m_acc.delete();
      m_start.delete();
      m_byte.delete();
      m_last_end = 0;
      m_ovr = 1'b0;
   endtask

   task automatic step(input logic wr, input logic [7:0] d);
      int n, s;
      WR_EN = wr;
      DATA  = d;
      n = cyc + 1;
      if (wr && !RST) begin
         if (count_at(n - 1) < DEPTH) begin
            s = (n + 1 > m_last_end) ? n + 1 : m_last_end;
            m_acc.push_back(n);
            m_start.push_back(s);
            m_byte.push_back(d);
            m_last_end = s + FRAME;
         end else begin
            m_ovr = 1'b1;
         end
      end
      @(posedge CLK);
      cyc = n;
      @(negedge CLK);
      WR_EN = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   task automatic async_reset_check(input string tag);
      #2 RST = 1'b1;
      model_reset();
      #1;
      chk({tag, "_TX"},      32'(TX),      32'(1));
      chk({tag, "_COUNT"},   32'(COUNT),   32'(0));
      chk({tag, "_BUSY"},    32'(BUSY),    32'(0));
      chk({tag, "_OVERRUN"}, 32'(OVERRUN), 32'(0));
      chk({tag, "_EMPTY"},   32'(EMPTY),   32'(1));
      chk({tag, "_FULL"},    32'(FULL),    32'(0));
   endtask

   initial begin
      int pop_edge;
      int burst;

      async_reset_check("RST0");
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      RST = 1'b0;
      idle(3);

      // Single 0x55 frame
      step(1'b1, 8'h55);
      idle(FRAME + 5);

      // Three-byte burst, frames chained without gaps
      step(1'b1, 8'h41);
      step(1'b1, 8'h42);
      step(1'b1, 8'h43);
      idle(3 * FRAME + 5);

      // Fill the FIFO while one frame is in flight; the 17th write overruns
      step(1'b1, 8'hC0);
      idle(3);
      for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i));
      chk("OVR_SET", 32'(OVERRUN), 32'(1));
      idle(17 * FRAME + 5);
      chk("OVR_STICKY", 32'(OVERRUN), 32'(1));

      // COUNT held at 1 through STOP with a write on the pop edge
      step(1'b1, 8'h3C);
      idle(4);
      step(1'b1, 8'hC3);
      pop_edge = m_start[m_start.size() - 1];
      while (cyc + 1 < pop_edge) step(1'b0, 8'h00);
      step(1'b1, 8'h5A);
      chk("POP_WR_COUNT", 32'(COUNT), 32'(1));
      idle(2 * FRAME + 5);

      // Reset during data bit 3 of 0xA5 with four bytes queued
      step(1'b1, 8'hA5);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i));
      idle(14);
      async_reset_check("RSTMID");
      step(1'b0, 8'h00);
      RST = 1'b0;
      idle(2 * FRAME);

      // All-zero and all-one bytes
      step(1'b1, 8'h00);
      step(1'b1, 8'hFF);
      idle(2 * FRAME + 5);

      // Randomized sparse traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 24) == 0, 8'($urandom));
      idle(2 * FRAME);

      // Randomized bursts, sometimes long enough to overrun
      for (int b = 0; b < 3; b++) begin
         burst = $urandom_range(1, 20);
         for (int i = 0; i < burst; i++) step(1'b1, 8'($urandom));
         idle($urandom_range(5, 60));
      end
      idle(DEPTH * FRAME + 10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
